// File: rtl/muldiv_ctrl.sv
// Sequencer between the execute stage and the shared multiplier/divider units.
// Owns HI/LO and drives both units over a toggle-request / level-compare-ack handshake.
module muldiv_ctrl (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_signed_o,
    output logic        mul_req_o,
    input  logic        mul_ack_i,
    input  logic [63:0] mul_product_i,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_signed_o,
    output logic        div_req_o,
    input  logic        div_ack_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDrain} state_e;

    state_e      state_q, state_d;
    logic        drain_div_q, drain_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        mul_signed_q, mul_signed_d;
    logic        mul_req_q, mul_req_d;
    logic [31:0] div_a_q, div_a_d;
    logic [31:0] div_b_q, div_b_d;
    logic        div_signed_q, div_signed_d;
    logic        div_req_q, div_req_d;

    logic mul_match;
    logic div_match;
    logic accept;

    // A unit is finished whenever its ack level has caught up with our request level.
    assign mul_match = (mul_ack_i == mul_req_q);
    assign div_match = (div_ack_i == div_req_q);
    assign accept    = op_valid_i && !flush_i;

    always_comb begin
        state_d      = state_q;
        drain_div_d  = drain_div_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        done_d       = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        mul_req_d    = mul_req_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_signed_d = div_signed_q;
        div_req_d    = div_req_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op_i)
                        OpMult, OpMultu: begin
                            mul_a_d      = a_i;
                            mul_b_d      = b_i;
                            mul_signed_d = (op_i == OpMult);
                            mul_req_d    = ~mul_req_q;
                            state_d      = StMulWait;
                        end
                        OpDiv, OpDivu: begin
                            if (b_i != 32'd0) begin
                                div_a_d      = a_i;
                                div_b_d      = b_i;
                                div_signed_d = (op_i == OpDiv);
                                div_req_d    = ~div_req_q;
                                state_d      = StDivWait;
                            end else begin
                                // Divide by zero never reaches the divider.
                                hi_d   = a_i;
                                lo_d   = 32'hFFFF_FFFF;
                                done_d = 1'b1;
                            end
                        end
                        OpMthi:  hi_d = a_i;
                        OpMtlo:  lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            StMulWait: begin
                if (mul_match) begin
                    hi_d    = mul_product_i[63:32];
                    lo_d    = mul_product_i[31:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (flush_i) begin
                    drain_div_d = 1'b0;
                    state_d     = StDrain;
                end
            end
            StDivWait: begin
                if (div_match) begin
                    hi_d    = div_remainder_i;
                    lo_d    = div_quotient_i;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (flush_i) begin
                    drain_div_d = 1'b1;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                // Units cannot be aborted; wait out the flushed operation silently.
                if (drain_div_q ? div_match : mul_match) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            state_q      <= StIdle;
            drain_div_q  <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            done_q       <= 1'b0;
            mul_a_q      <= 32'd0;
            mul_b_q      <= 32'd0;
            mul_signed_q <= 1'b0;
            mul_req_q    <= 1'b0;
            div_a_q      <= 32'd0;
            div_b_q      <= 32'd0;
            div_signed_q <= 1'b0;
            div_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_div_q  <= drain_div_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            done_q       <= done_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            mul_req_q    <= mul_req_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_signed_q <= div_signed_d;
            div_req_q    <= div_req_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_signed_o = mul_signed_q;
    assign mul_req_o    = mul_req_q;
    assign div_a_o      = div_a_q;
    assign div_b_o      = div_b_q;
    assign div_signed_o = div_signed_q;
    assign div_req_o    = div_req_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural mul/div units with programmable
// latency, an arithmetic HI/LO reference model, directed and randomized scenarios.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic        mul_req;
    logic        mul_ack;
    logic [63:0] mul_product;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_signed;
    logic        div_req;
    logic        div_ack;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int tests  = 0;
    int failed = 0;

    int mul_lat = 0;
    int div_lat = 0;
    int mul_cnt;
    int div_cnt;

    // Reference model state.
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic        mul_req_m;
    logic        div_req_m;

    muldiv_ctrl dut (
        .sys_clock_i     (clk),
        .sys_reset_i     (rst),
        .op_valid_i      (op_valid),
        .op_i            (op_code),
        .a_i             (a_in),
        .b_i             (b_in),
        .flush_i         (flush),
        .busy_o          (busy),
        .done_o          (done),
        .hi_o            (hi),
        .lo_o            (lo),
        .mul_a_o         (mul_a),
        .mul_b_o         (mul_b),
        .mul_signed_o    (mul_signed),
        .mul_req_o       (mul_req),
        .mul_ack_i       (mul_ack),
        .mul_product_i   (mul_product),
        .div_a_o         (div_a),
        .div_b_o         (div_b),
        .div_signed_o    (div_signed),
        .div_req_o       (div_req),
        .div_ack_i       (div_ack),
        .div_quotient_i  (div_quot),
        .div_remainder_i (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: starts on a request toggle, acks after mul_lat+1 edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_ack     <= 1'b0;
            mul_cnt     <= 0;
            mul_product <= '0;
        end else if (mul_req != mul_ack) begin
            if (mul_cnt >= mul_lat) begin
                mul_ack     <= mul_req;
                mul_cnt     <= 0;
                mul_product <= mul_signed ?
                    {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b} :
                    {32'b0, mul_a} * {32'b0, mul_b};
            end else begin
                mul_cnt <= mul_cnt + 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            div_ack  <= 1'b0;
            div_cnt  <= 0;
            div_quot <= '0;
            div_rem  <= '0;
        end else if (div_req != div_ack) begin
            if (div_cnt >= div_lat) begin
                div_ack <= div_req;
                div_cnt <= 0;
                if (div_signed) begin
                    div_quot <= $signed(div_a) / $signed(div_b);
                    div_rem  <= $signed(div_a) % $signed(div_b);
                end else begin
                    div_quot <= div_a / div_b;
                    div_rem  <= div_a % div_b;
                end
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    function automatic void ref_apply(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          q;
        int          r;
        case (op)
            0: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            1: begin
                p = 64'(longint'({32'b0, a}) * longint'({32'b0, b}));
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            2, 3: begin
                if (b == 32'd0) begin
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
                end else if (op == 2) begin
                    q = int'(a) / int'(b);
                    r = int'(a) % int'(b);
                    lo_m = q;
                    hi_m = r;
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            4: hi_m = a;
            5: lo_m = a;
            default: ;
        endcase
    endfunction

    // Drives one command for one cycle; call at a negedge, returns at the next negedge.
    task automatic issue_op(input int op, input logic [31:0] a, input logic [31:0] b);
        if (!busy && !flush) begin
            if (op <= 1) mul_req_m = ~mul_req_m;
            else if (op <= 3 && b != 32'd0) div_req_m = ~div_req_m;
        end
        op_valid = 1'b1;
        op_code  = 3'(op);
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_result(output int cyc, output int ndone, output int drop);
        cyc   = 0;
        ndone = 0;
        drop  = 0;
        while (cyc < 300 && ndone == 0) begin
            @(negedge clk);
            cyc++;
            if (done) ndone++;
            else if (!busy) drop++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        hi_m      = '0;
        lo_m      = '0;
        mul_req_m = 1'b0;
        div_req_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            failed++;
            $display("FAIL reset_status: got busy=%b done=%b hi=%h lo=%h want 0", busy, done, hi, lo);
        end
        tests++;
        if ({mul_a, mul_b, mul_signed, mul_req} !== 66'd0) begin
            failed++;
            $display("FAIL reset_mul: got a=%h b=%h s=%b req=%b want 0", mul_a, mul_b, mul_signed,
                     mul_req);
        end
        tests++;
        if ({div_a, div_b, div_signed, div_req} !== 66'd0) begin
            failed++;
            $display("FAIL reset_div: got a=%h b=%h s=%b req=%b want 0", div_a, div_b, div_signed,
                     div_req);
        end
        do_reset();
    endtask

    task automatic test_mul();
        int cyc, nd, drop;
        mul_lat = 3;
        issue_op(1, 32'd17, 32'd3);
        tests++;
        if ({busy, mul_req, mul_signed, mul_a, mul_b} !== {1'b1, 1'b1, 1'b0, 32'd17, 32'd3}) begin
            failed++;
            $display("FAIL multu_launch: got busy=%b req=%b s=%b a=%0d b=%0d want 1 1 0 17 3", busy,
                     mul_req, mul_signed, mul_a, mul_b);
        end
        wait_result(cyc, nd, drop);
        tests++;
        if (nd != 1 || drop != 0 || cyc != 5) begin
            failed++;
            $display("FAIL multu_timing: got done=%0d drops=%0d cycles=%0d want 1 0 5", nd, drop, cyc);
        end
        tests++;
        if ({hi, lo, busy} !== {32'd0, 32'd51, 1'b0}) begin
            failed++;
            $display("FAIL multu_result: got hi=%h lo=%h busy=%b want 0 33 0", hi, lo, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL multu_done_once: got done=%b want 0", done);
        end
        mul_lat = 5;
        issue_op(0, 32'hFFFF_FFF9, 32'd3);
        tests++;
        if ({mul_signed, mul_req, busy} !== 3'b101) begin
            failed++;
            $display("FAIL mult_launch: got s=%b req=%b busy=%b want 1 0 1", mul_signed, mul_req, busy);
        end
        wait_result(cyc, nd, drop);
        tests++;
        if (nd != 1 || {hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            failed++;
            $display("FAIL mult_result: got done=%0d hi=%h lo=%h want 1 ffffffff ffffffeb", nd, hi, lo);
        end
    endtask

    task automatic test_div();
        int cyc, nd, drop;
        div_lat = 4;
        issue_op(3, 32'd17, 32'd5);
        tests++;
        if ({div_req, div_signed, busy} !== 3'b101) begin
            failed++;
            $display("FAIL divu_launch: got req=%b s=%b busy=%b want 1 0 1", div_req, div_signed, busy);
        end
        wait_result(cyc, nd, drop);
        tests++;
        if (nd != 1 || cyc != 6 || {hi, lo} !== {32'd2, 32'd3}) begin
            failed++;
            $display("FAIL divu_result: got done=%0d cyc=%0d hi=%0d lo=%0d want 1 6 2 3", nd, cyc, hi, lo);
        end
        div_lat = 1;
        issue_op(2, 32'd20, 32'd4);
        tests++;
        if ({div_req, div_signed} !== 2'b01) begin
            failed++;
            $display("FAIL div_launch: got req=%b s=%b want 0 1", div_req, div_signed);
        end
        wait_result(cyc, nd, drop);
        tests++;
        if (nd != 1 || {hi, lo} !== {32'd0, 32'd5}) begin
            failed++;
            $display("FAIL div_result: got done=%0d hi=%0d lo=%0d want 1 0 5", nd, hi, lo);
        end
    endtask

    task automatic test_div_zero();
        issue_op(2, 32'd9, 32'd0);
        tests++;
        if ({done, busy, div_req, hi, lo} !== {1'b1, 1'b0, 1'b0, 32'd9, 32'hFFFF_FFFF}) begin
            failed++;
            $display("FAIL div_zero: got done=%b busy=%b req=%b hi=%h lo=%h want 1 0 0 9 ffffffff",
                     done, busy, div_req, hi, lo);
        end
        @(negedge clk);
        tests++;
        if ({done, busy} !== 2'b00) begin
            failed++;
            $display("FAIL div_zero_after: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_flush();
        int k, nd;
        flush = 1'b1;
        issue_op(4, 32'h5555_5555, 32'd0);
        flush = 1'b0;
        tests++;
        if (hi !== 32'd9) begin
            failed++;
            $display("FAIL flush_blocks_accept: got hi=%h want 9", hi);
        end
        mul_lat = 10;
        issue_op(1, 32'd5, 32'd5);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issue_op(5, 32'h0000_ABCD, 32'd0);
        tests++;
        if ({busy, done, lo} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin
            failed++;
            $display("FAIL drain_ignores_mtlo: got busy=%b done=%b lo=%h want 1 0 ffffffff", busy,
                     done, lo);
        end
        k  = 0;
        nd = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
            if (done) nd++;
        end
        tests++;
        if (k != 7 || nd != 0) begin
            failed++;
            $display("FAIL drain_length: got cycles=%0d done=%0d want 7 0", k, nd);
        end
        tests++;
        if ({hi, lo} !== {32'd9, 32'hFFFF_FFFF}) begin
            failed++;
            $display("FAIL drain_hilo: got hi=%h lo=%h want 9 ffffffff", hi, lo);
        end
        issue_op(5, 32'h0000_ABCD, 32'd0);
        tests++;
        if (lo !== 32'h0000_ABCD) begin
            failed++;
            $display("FAIL mtlo_after_drain: got lo=%h want abcd", lo);
        end
    endtask

    task automatic test_flush_vs_complete();
        mul_lat = 2;
        issue_op(1, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if ({done, busy, hi, lo} !== {1'b1, 1'b0, 32'd0, 32'd42}) begin
            failed++;
            $display("FAIL complete_wins: got done=%b busy=%b hi=%h lo=%h want 1 0 0 2a", done, busy,
                     hi, lo);
        end
    endtask

    task automatic test_random();
        int op, lat, cyc, nd, drop;
        logic [31:0] a, b;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 40);
                b = $urandom_range(0, 9);
            end
            if ($urandom_range(0, 4) == 0) b = 32'd0;
            if (op == 2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            mul_lat = $urandom_range(0, 6);
            div_lat = $urandom_range(0, 6);
            lat = (op <= 1) ? mul_lat : div_lat;
            issue_op(op, a, b);
            ref_apply(op, a, b);
            tests++;
            if ({mul_req, div_req} !== {mul_req_m, div_req_m}) begin
                failed++;
                $display("FAIL rnd_req[%0d]: got %b%b want %b%b", i, mul_req, div_req, mul_req_m,
                         div_req_m);
            end
            if (op <= 1 || (op <= 3 && b != 32'd0)) begin
                tests++;
                if (op <= 1 && {busy, mul_a, mul_b, mul_signed} !== {1'b1, a, b, op == 0}) begin
                    failed++;
                    $display("FAIL rnd_mul_ops[%0d]: got busy=%b a=%h b=%h s=%b", i, busy, mul_a,
                             mul_b, mul_signed);
                end else if (op > 1 && {busy, div_a, div_b, div_signed} !== {1'b1, a, b, op == 2}) begin
                    failed++;
                    $display("FAIL rnd_div_ops[%0d]: got busy=%b a=%h b=%h s=%b", i, busy, div_a,
                             div_b, div_signed);
                end
                wait_result(cyc, nd, drop);
                tests++;
                if (nd != 1 || drop != 0 || cyc != lat + 2 || busy !== 1'b0) begin
                    failed++;
                    $display("FAIL rnd_timing[%0d]: got done=%0d drops=%0d cyc=%0d busy=%b want 1 0 %0d 0",
                             i, nd, drop, cyc, busy, lat + 2);
                end
            end else begin
                tests++;
                if ({busy, done} !== {1'b0, (op == 2 || op == 3)}) begin
                    failed++;
                    $display("FAIL rnd_short[%0d] op=%0d: got busy=%b done=%b", i, op, busy, done);
                end
            end
            tests++;
            if ({hi, lo} !== {hi_m, lo_m}) begin
                failed++;
                $display("FAIL rnd_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b,
                         hi, lo, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc, nd, drop;
        issue_op(4, 32'h0000_1234, 32'd0);
        mul_lat = 20;
        issue_op(1, 32'd9, 32'd9);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, hi, lo, mul_a, mul_b, mul_signed, mul_req} !== 132'd0) begin
            failed++;
            $display("FAIL async_reset: got busy=%b hi=%h lo=%h a=%h b=%h req=%b want 0", busy, hi,
                     lo, mul_a, mul_b, mul_req);
        end
        @(negedge clk);
        rst       = 1'b0;
        mul_req_m = 1'b0;
        div_req_m = 1'b0;
        @(negedge clk);
        mul_lat = 1;
        issue_op(1, 32'd2, 32'd3);
        wait_result(cyc, nd, drop);
        tests++;
        if (nd != 1 || cyc != 3 || {hi, lo} !== {32'd0, 32'd6}) begin
            failed++;
            $display("FAIL post_reset_mul: got done=%0d cyc=%0d hi=%h lo=%h want 1 3 0 6", nd, cyc,
                     hi, lo);
        end
    endtask

    initial begin
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        a_in      = '0;
        b_in      = '0;
        flush     = 1'b0;
        hi_m      = '0;
        lo_m      = '0;
        mul_req_m = 1'b0;
        div_req_m = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_flush_vs_complete();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
